// File: rtl/posit_chk_pkg.sv
// Shared types and default widths for the posit result stream checker.
package posit_chk_pkg;

  localparam int N_DEF     = 32;
  localparam int DEPTH_DEF = 8;
  localparam int IDX_W_DEF = 19;
  localparam int CNT_W_DEF = 16;

  // Run phases: waiting, accepting golden values, finishing compares, finished.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/posit_stream_checker_sync_fifo.sv
// Small synchronous FIFO holding golden results until the matching DUT result arrives.
// Pointers carry one extra MSB so full and empty can be told apart when the low bits match.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Status flags and head-of-queue data come straight from the pointer registers.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    rdata   = mem[rd_ptr[AW-1:0]];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointer update; clr empties the queue at the start of a new run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/posit_stream_checker.sv
// On-chip result checker for a posit adder/subtractor: queues golden results, pairs each
// DUT result with the oldest golden value, and keeps error / max-diff / first-error stats.
module posit_stream_checker
  import posit_chk_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_vectors,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [N-1:0]     exp_data,
  input  logic             dut_valid,
  input  logic [N-1:0]     dut_data,
  output logic             diff_valid,
  output logic [N-1:0]     diff,
  output logic [CNT_W-1:0] error_count,
  output logic [N-1:0]     max_diff,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             first_err_seen,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  chk_state_t       state;
  chk_state_t       state_nxt;
  logic [IDX_W-1:0] num_vec;
  logic [IDX_W-1:0] pushed;
  logic [IDX_W-1:0] checked;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic [N-1:0]     fifo_head;
  logic             start_ok;
  logic             in_check;
  logic             do_push;
  logic             do_pop;
  logic             empty_pop;
  logic [N:0]       sdiff;
  logic [N-1:0]     mag;

  sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (exp_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Handshake decode: which events actually happen this cycle.
  always_comb begin
    start_ok  = start && ((state == IDLE) || (state == DONE));
    in_check  = (state == RUN) || (state == DRAIN);
    do_push   = exp_valid && exp_ready;
    do_pop    = dut_valid && in_check && !fifo_empty;
    empty_pop = dut_valid && in_check && fifo_empty;
  end

  // Sign-extended subtraction; the magnitude of an N+1-bit difference always fits N bits.
  always_comb begin
    sdiff = {fifo_head[N-1], fifo_head} - {dut_data[N-1], dut_data};
    if (sdiff[N]) mag = ~sdiff[N-1:0] + N'(1);
    else          mag = sdiff[N-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; RUN may skip DRAIN when nothing is left to compare (e.g. empty runs).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (pushed == num_vec) begin
          if ((checked == num_vec) && (fifo_count == '0)) state_nxt = DONE;
          else                                             state_nxt = DRAIN;
        end
      end
      DRAIN: if ((checked == num_vec) && (fifo_count == '0)) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; the full flag is the registered one, so a same-cycle pop never frees a slot.
  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    exp_ready = (state == RUN) && !fifo_full && (pushed < num_vec);
  end

  // Run bookkeeping: vector count, golden values accepted, DUT results consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_vec <= '0;
      pushed  <= '0;
      checked <= '0;
    end else if (start_ok) begin
      num_vec <= num_vectors;
      pushed  <= '0;
      checked <= '0;
    end else begin
      if (do_push) pushed  <= pushed + IDX_W'(1);
      if (do_pop)  checked <= checked + IDX_W'(1);
    end
  end

  // Compare register; diff keeps its last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_valid <= 1'b0;
      diff       <= '0;
    end else if (start_ok) begin
      diff_valid <= 1'b0;
    end else begin
      diff_valid <= do_pop;
      if (do_pop) diff <= mag;
    end
  end

  // Statistics are folded in on the same edge as diff so they line up with diff_valid.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      error_count    <= '0;
      max_diff       <= '0;
      first_err_idx  <= '0;
      first_err_seen <= 1'b0;
    end else if (do_pop) begin
      if ((mag != '0) && (error_count != '1)) error_count <= error_count + CNT_W'(1);
      if (mag > max_diff) max_diff <= mag;
      if ((mag != '0) && !first_err_seen) begin
        first_err_idx  <= checked;
        first_err_seen <= 1'b1;
      end
    end
  end

  // Sticky flag for a DUT result that had no golden value waiting.
  always_ff @(posedge clk) begin
    if (rst || start_ok)  underflow <= 1'b0;
    else if (empty_pop)   underflow <= 1'b1;
  end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Self-checking bench for posit_stream_checker: directed scenarios plus randomized runs
// compared against a queue-based reference model.
module tb_posit_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] num_vectors;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_data;
  logic        dut_valid;
  logic [31:0] dut_data;
  logic        diff_valid;
  logic [31:0] diff;
  logic [15:0] error_count;
  logic [31:0] max_diff;
  logic [18:0] first_err_idx;
  logic        first_err_seen;
  logic        underflow;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  posit_stream_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vectors    (num_vectors),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_data       (exp_data),
    .dut_valid      (dut_valid),
    .dut_data       (dut_data),
    .diff_valid     (diff_valid),
    .diff           (diff),
    .error_count    (error_count),
    .max_diff       (max_diff),
    .first_err_idx  (first_err_idx),
    .first_err_seen (first_err_seen),
    .underflow      (underflow),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Absolute difference of two words read as signed 32-bit integers.
  function automatic logic [31:0] ref_absdiff(input logic [31:0] e, input logic [31:0] d);
    longint a, b, r;
    a = longint'($signed(e));
    b = longint'($signed(d));
    r = a - b;
    if (r < 0) r = -r;
    return r[31:0];
  endfunction

  // Pulse start at the current negedge; returns at the next negedge (first RUN cycle).
  task automatic do_start(input int nv);
    start       = 1'b1;
    num_vectors = 19'(nv);
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("[TB] FAIL reset_done got=%0h exp=0", done); end
    checks++; if (exp_ready !== 1'b0)     begin errors++; $display("[TB] FAIL reset_exp_ready got=%0h exp=0", exp_ready); end
    checks++; if (diff_valid !== 1'b0)    begin errors++; $display("[TB] FAIL reset_diff_valid got=%0h exp=0", diff_valid); end
    checks++; if (diff !== 32'h0)         begin errors++; $display("[TB] FAIL reset_diff got=%0h exp=0", diff); end
    checks++; if (error_count !== 16'h0)  begin errors++; $display("[TB] FAIL reset_error_count got=%0h exp=0", error_count); end
    checks++; if (max_diff !== 32'h0)     begin errors++; $display("[TB] FAIL reset_max_diff got=%0h exp=0", max_diff); end
    checks++; if (first_err_seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_seen got=%0h exp=0", first_err_seen); end
    checks++; if (first_err_idx !== 19'h0) begin errors++; $display("[TB] FAIL reset_first_idx got=%0h exp=0", first_err_idx); end
    checks++; if (underflow !== 1'b0)     begin errors++; $display("[TB] FAIL reset_underflow got=%0h exp=0", underflow); end
  endtask

  task automatic test_equal_run();
    logic [31:0] v [3];
    int pulses = 0;
    v[0] = 32'h4000_0000; v[1] = 32'h4800_0000; v[2] = 32'h3800_0000;
    do_start(3);
    for (int c = 0; c < 6; c++) begin
      if (diff_valid === 1'b1) begin
        pulses++;
        checks++; if (diff !== 32'h0) begin errors++; $display("[TB] FAIL equal_diff got=%0h exp=0", diff); end
      end
      if (c < 3) begin
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("[TB] FAIL equal_exp_ready got=%0h exp=1", exp_ready); end
        exp_valid = 1'b1; exp_data = v[c];
      end else begin
        exp_valid = 1'b0; exp_data = 32'h0;
      end
      if (c >= 1 && c < 4) begin dut_valid = 1'b1; dut_data = v[c-1]; end
      else                 begin dut_valid = 1'b0; dut_data = 32'h0; end
      @(negedge clk);
    end
    for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
    checks++; if (done !== 1'b1)          begin errors++; $display("[TB] FAIL equal_done got=%0h exp=1", done); end
    checks++; if (pulses != 3)            begin errors++; $display("[TB] FAIL equal_pulses got=%0d exp=3", pulses); end
    checks++; if (error_count !== 16'h0)  begin errors++; $display("[TB] FAIL equal_error_count got=%0h exp=0", error_count); end
    checks++; if (max_diff !== 32'h0)     begin errors++; $display("[TB] FAIL equal_max_diff got=%0h exp=0", max_diff); end
  endtask

  task automatic test_signed_boundaries();
    do_start(2);
    exp_valid = 1'b1; exp_data = 32'h0000_0005; dut_valid = 1'b0;
    @(negedge clk);
    exp_valid = 1'b1; exp_data = 32'h7FFF_FFFF; dut_valid = 1'b1; dut_data = 32'hFFFF_FFFB;
    @(negedge clk);
    checks++; if (diff_valid !== 1'b1)      begin errors++; $display("[TB] FAIL small_diff_valid got=%0h exp=1", diff_valid); end
    checks++; if (diff !== 32'h0000_000A)   begin errors++; $display("[TB] FAIL small_diff got=%0h exp=a", diff); end
    checks++; if (error_count !== 16'd1)    begin errors++; $display("[TB] FAIL small_error_count got=%0h exp=1", error_count); end
    checks++; if (first_err_seen !== 1'b1)  begin errors++; $display("[TB] FAIL small_first_seen got=%0h exp=1", first_err_seen); end
    checks++; if (first_err_idx !== 19'd0)  begin errors++; $display("[TB] FAIL small_first_idx got=%0h exp=0", first_err_idx); end
    exp_valid = 1'b0; dut_valid = 1'b1; dut_data = 32'h8000_0000;
    @(negedge clk);
    dut_valid = 1'b0;
    checks++; if (diff !== 32'hFFFF_FFFF)     begin errors++; $display("[TB] FAIL wide_diff got=%0h exp=ffffffff", diff); end
    checks++; if (max_diff !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wide_max_diff got=%0h exp=ffffffff", max_diff); end
    checks++; if (error_count !== 16'd2)      begin errors++; $display("[TB] FAIL wide_error_count got=%0h exp=2", error_count); end
    checks++; if (first_err_idx !== 19'd0)    begin errors++; $display("[TB] FAIL wide_first_idx got=%0h exp=0", first_err_idx); end
    for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL signed_done got=%0h exp=1", done); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] vals [8];
    do_start(10);
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      checks++; if (exp_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_exp_ready got=%0h exp=1", exp_ready); end
      exp_valid = 1'b1; exp_data = vals[i];
      start = (i == 4);
      num_vectors = 19'd0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_exp_ready got=%0h exp=0", exp_ready); end
    exp_data = ~vals[1];
    @(negedge clk);
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL still_full_exp_ready got=%0h exp=0", exp_ready); end
    exp_valid = 1'b0; dut_valid = 1'b1; dut_data = vals[0];
    @(negedge clk);
    checks++; if (exp_ready !== 1'b1)  begin errors++; $display("[TB] FAIL after_pop_exp_ready got=%0h exp=1", exp_ready); end
    checks++; if (diff_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_valid got=%0h exp=1", diff_valid); end
    checks++; if (diff !== 32'h0)      begin errors++; $display("[TB] FAIL full_pop0_diff got=%0h exp=0", diff); end
    dut_data = vals[1];
    @(negedge clk);
    dut_valid = 1'b0;
    checks++; if (diff !== 32'h0)      begin errors++; $display("[TB] FAIL full_pop1_diff got=%0h exp=0", diff); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_abort_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_underflow();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    do_start(2);
    exp_valid = 1'b1; exp_data = a; dut_valid = 1'b1; dut_data = a;
    @(negedge clk);
    checks++; if (underflow !== 1'b1)    begin errors++; $display("[TB] FAIL uf_set got=%0h exp=1", underflow); end
    checks++; if (diff_valid !== 1'b0)   begin errors++; $display("[TB] FAIL uf_no_compare got=%0h exp=0", diff_valid); end
    exp_data = b; dut_data = a;
    @(negedge clk);
    checks++; if (diff_valid !== 1'b1)   begin errors++; $display("[TB] FAIL uf_pop_valid got=%0h exp=1", diff_valid); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("[TB] FAIL uf_error_count got=%0h exp=0", error_count); end
    exp_valid = 1'b0; dut_data = b ^ 32'h1;
    @(negedge clk);
    dut_valid = 1'b0;
    checks++; if (diff !== 32'h1)          begin errors++; $display("[TB] FAIL uf_diff got=%0h exp=1", diff); end
    checks++; if (first_err_idx !== 19'd1) begin errors++; $display("[TB] FAIL uf_first_idx got=%0h exp=1", first_err_idx); end
    checks++; if (underflow !== 1'b1)      begin errors++; $display("[TB] FAIL uf_sticky got=%0h exp=1", underflow); end
    for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL uf_done got=%0h exp=1", done); end
    do_start(0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_cleared got=%0h exp=0", underflow); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL zero_busy got=%0h exp=1", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1)      begin errors++; $display("[TB] FAIL zero_done got=%0h exp=1", done); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] vals [5];
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    do_start(5);
    for (int c = 0; c < 4; c++) begin
      exp_valid = 1'b1; exp_data = vals[c];
      if (c >= 1 && c <= 2) begin dut_valid = 1'b1; dut_data = vals[c-1] ^ 32'h10; end
      else                     dut_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (error_count !== 16'd2) begin errors++; $display("[TB] FAIL mid_error_count got=%0h exp=2", error_count); end
    checks++; if (max_diff !== 32'h10)   begin errors++; $display("[TB] FAIL mid_max_diff got=%0h exp=10", max_diff); end
    rst = 1'b1; dut_valid = 1'b1; dut_data = 32'h0;
    @(negedge clk);
    rst = 1'b0; exp_valid = 1'b0; dut_valid = 1'b0;
    checks++; if ({busy, done, exp_ready, diff_valid, first_err_seen, underflow} !== 6'b0)
      begin errors++; $display("[TB] FAIL abort_flags got=%0b exp=0", {busy, done, exp_ready, diff_valid, first_err_seen, underflow}); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("[TB] FAIL abort_error_count got=%0h exp=0", error_count); end
    checks++; if (max_diff !== 32'h0)    begin errors++; $display("[TB] FAIL abort_max_diff got=%0h exp=0", max_diff); end
    checks++; if (diff !== 32'h0)        begin errors++; $display("[TB] FAIL abort_diff got=%0h exp=0", diff); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got=%0h exp=0", busy); end
    do_start(0);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_zero_run got=%0h exp=0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL abort_zero_done got=%0h exp=1", done); end
  endtask

  task automatic test_random_run(input int nv);
    logic [31:0] q[$];
    logic [31:0] head, d, dexp, max_m;
    int pushed_m, checked_m, err_m, first_m, cycles;
    bit seen_m, dv_m, ready_m, pu, po;
    pushed_m = 0; checked_m = 0; err_m = 0; first_m = 0; cycles = 0;
    seen_m = 0; dv_m = 0; max_m = 32'h0; dexp = 32'h0;
    do_start(nv);
    while ((pushed_m < nv || checked_m < nv) && cycles < 3000) begin
      ready_m = (pushed_m < nv) && (q.size() < 8);
      checks++; if (exp_ready !== ready_m) begin errors++; $display("[TB] FAIL rnd_exp_ready got=%0h exp=%0h", exp_ready, ready_m); end
      checks++; if (diff_valid !== dv_m)   begin errors++; $display("[TB] FAIL rnd_diff_valid got=%0h exp=%0h", diff_valid, dv_m); end
      if (dv_m) begin
        checks++; if (diff !== dexp) begin errors++; $display("[TB] FAIL rnd_diff got=%0h exp=%0h", diff, dexp); end
      end
      checks++; if (error_count !== 16'(err_m)) begin errors++; $display("[TB] FAIL rnd_error_count got=%0h exp=%0h", error_count, err_m); end
      checks++; if (max_diff !== max_m)         begin errors++; $display("[TB] FAIL rnd_max_diff got=%0h exp=%0h", max_diff, max_m); end
      checks++; if (first_err_seen !== seen_m)  begin errors++; $display("[TB] FAIL rnd_first_seen got=%0h exp=%0h", first_err_seen, seen_m); end
      if (seen_m) begin
        checks++; if (first_err_idx !== 19'(first_m)) begin errors++; $display("[TB] FAIL rnd_first_idx got=%0h exp=%0h", first_err_idx, first_m); end
      end
      pu = ready_m && ($urandom_range(0, 3) != 0);
      po = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      exp_valid = pu || (!ready_m && ($urandom_range(0, 1) == 1));
      exp_data  = $urandom;
      dut_valid = po;
      dv_m      = po;
      if (po) begin
        head = q.pop_front();
        case ($urandom_range(0, 3))
          0, 1:    dut_data = head;
          2:       dut_data = head + 32'($urandom_range(1, 100));
          default: dut_data = $urandom;
        endcase
        d = ref_absdiff(head, dut_data);
        dexp = d;
        if (d != 32'h0) begin
          if (err_m < 65535) err_m++;
          if (!seen_m) begin seen_m = 1; first_m = checked_m; end
        end
        if (d > max_m) max_m = d;
        checked_m++;
      end
      if (pu) begin q.push_back(exp_data); pushed_m++; end
      @(negedge clk);
      cycles++;
    end
    exp_valid = 1'b0; dut_valid = 1'b0;
    checks++; if (cycles >= 3000) begin errors++; $display("[TB] FAIL rnd_timeout got=%0d exp<3000", cycles); end
    checks++; if (diff_valid !== dv_m) begin errors++; $display("[TB] FAIL rnd_last_valid got=%0h exp=%0h", diff_valid, dv_m); end
    checks++; if (diff !== dexp)       begin errors++; $display("[TB] FAIL rnd_last_diff got=%0h exp=%0h", diff, dexp); end
    checks++; if (error_count !== 16'(err_m)) begin errors++; $display("[TB] FAIL rnd_final_errors got=%0h exp=%0h", error_count, err_m); end
    checks++; if (max_diff !== max_m)  begin errors++; $display("[TB] FAIL rnd_final_max got=%0h exp=%0h", max_diff, max_m); end
    for (int k = 0; k < 8 && done !== 1'b1; k++) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rnd_done got=%0h exp=1", done); end
  endtask

  // Global time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_vectors = 19'd0;
    exp_valid = 1'b0; exp_data = 32'h0; dut_valid = 1'b0; dut_data = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_equal_run();
    test_signed_boundaries();
    test_fifo_full();
    test_underflow();
    test_reset_midrun();
    test_random_run(20);
    test_random_run(int'($urandom_range(5, 40)));
    test_random_run(int'($urandom_range(30, 60)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
